ata_pio_ctl: RTL and testbench

- Parametrised successor to the fixed-timing Gayle/Atari IDE strobe generator.
- Decodes the IDE window from the CPU bus and runs an ATA PIO cycle through a programmable setup/active/recovery timing engine.
- Extends the cycle on drive IORDY (WAIT) and terminates with DTACK.
- Sits between the 68k bus glue and the IDE connector, one instance per IDE port.

---
 rtl/ata_pkg.sv | 74 +++++++
 rtl/ata_pio_timer.sv | 35 +++
 rtl/ata_pio_ctl.sv | 194 +++++++++++++++++++
 tb/tb_ata_pio_ctl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ata_pkg.sv
// rtl/ata_pkg.sv - shared types and board constants for the ATA PIO controller
package ata_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACTIVE,
        ST_WAITRDY,
        ST_ACK,
        ST_RECOVER
    } ata_state_e;

    typedef enum logic [1:0] {
        CLK_7MHZ,
        CLK_25MHZ,
        CLK_50MHZ
    } board_clk_e;

    typedef struct packed {
        logic [7:0] setup_cyc;
        logic [7:0] active_cyc;
        logic [7:0] recovery_cyc;
    } pio_timing_t;

    localparam logic [23:0] AMIGA_IDE_BASE   = 24'hDA0000;
    localparam logic [23:0] AMIGA_IDE_MASK   = 24'hFF8000;
    localparam int          AMIGA_IDE_CS_BIT = 12;

    localparam logic [23:0] ATARI_IDE_BASE   = 24'hF00000;
    localparam logic [23:0] ATARI_IDE_MASK   = 24'hFFFFC0;
    localparam int          ATARI_IDE_CS_BIT = 5;

    // Cycle counts are ceil(t * f_clk) of the 16-bit PIO t1/t2/max(t2i, t0-t1-t2)
    function automatic pio_timing_t pio_mode_timing(input board_clk_e clk_sel,
                                                    input logic [2:0] mode);
        logic [7:0] s;
        logic [7:0] a;
        logic [7:0] r;
        s = 8'd1;
        a = 8'd2;
        r = 8'd3;
        case (clk_sel)
            CLK_7MHZ: begin
                case (mode)
                    3'd1:    begin s = 8'd1; a = 8'd1; r = 8'd2; end
                    3'd2:    begin s = 8'd1; a = 8'd1; r = 8'd1; end
                    3'd3:    begin s = 8'd1; a = 8'd1; r = 8'd1; end
                    3'd4:    begin s = 8'd1; a = 8'd1; r = 8'd1; end
                    default: begin s = 8'd1; a = 8'd2; r = 8'd3; end
                endcase
            end
            CLK_25MHZ: begin
                case (mode)
                    3'd1:    begin s = 8'd2; a = 8'd4; r = 8'd6;  end
                    3'd2:    begin s = 8'd1; a = 8'd3; r = 8'd3;  end
                    3'd3:    begin s = 8'd1; a = 8'd2; r = 8'd2;  end
                    3'd4:    begin s = 8'd1; a = 8'd2; r = 8'd1;  end
                    default: begin s = 8'd2; a = 8'd5; r = 8'd10; end
                endcase
            end
            default: begin
                case (mode)
                    3'd1:    begin s = 8'd3; a = 8'd7; r = 8'd11; end
                    3'd2:    begin s = 8'd2; a = 8'd5; r = 8'd6;  end
                    3'd3:    begin s = 8'd2; a = 8'd4; r = 8'd4;  end
                    3'd4:    begin s = 8'd2; a = 8'd4; r = 8'd2;  end
                    default: begin s = 8'd4; a = 8'd9; r = 8'd19; end
                endcase
            end
        endcase
        return '{setup_cyc: s, active_cyc: a, recovery_cyc: r};
    endfunction

endpackage

// File: rtl/ata_pio_timer.sv
// rtl/ata_pio_timer.sv - loadable down-counter shared by setup/active/recovery phases
module ata_pio_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/ata_pio_ctl.sv
// rtl/ata_pio_ctl.sv - IDE window decode and ATA PIO cycle engine; ATA_IORDY_TIMEOUT_EN builds the IORDY watchdog
module ata_pio_ctl
    import ata_pkg::*;
#(
    parameter int                ADDR_W       = 24,
    parameter logic [ADDR_W-1:0] BASE         = ADDR_W'(AMIGA_IDE_BASE),
    parameter logic [ADDR_W-1:0] BASE_MASK    = ADDR_W'(AMIGA_IDE_MASK),
    parameter int                CS_BIT       = AMIGA_IDE_CS_BIT,
    parameter int                CNT_W        = 8,
    parameter int                SETUP_CYC    = 1,
    parameter int                ACTIVE_CYC   = 4,
    parameter int                RECOVERY_CYC = 2,
    parameter int                TIMEOUT_CYC  = 200
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              AS,
    input  logic              RW,
    input  logic [ADDR_W-1:0] A,
    input  logic              WAIT,
    output logic [1:0]        IDECS,
    output logic              IOR,
    output logic              IOW,
    output logic              DTACK,
    output logic              ACCESS,
    output logic              BUSY,
    output logic              TIMEOUT_ERR
);

    localparam logic [CNT_W-1:0] SETUP_LOAD    = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] ACTIVE_LOAD   = CNT_W'(ACTIVE_CYC - 1);
    localparam logic [CNT_W-1:0] RECOVERY_LOAD = CNT_W'(RECOVERY_CYC - 1);

    ata_state_e       state_q, state_d;
    logic             rw_q, rw_d;
    logic [1:0]       idecs_q, idecs_d;
    logic             ior_q, ior_d;
    logic             iow_q, iow_d;
    logic             dtack_q, dtack_d;
    logic             busy_q;
    logic             addr_match;
    logic             hit;
    logic             to_expired;
    logic             tmr_load;
    logic             tmr_dec;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_zero;

    assign addr_match = ((A & BASE_MASK) == (BASE & BASE_MASK));
    assign hit        = !AS && addr_match;
    assign ACCESS     = !addr_match;

    ata_pio_timer #(.CNT_W(CNT_W)) u_timer (
        .clk_i      (CLK),
        .reset_i    (RESET),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .dec_i      (tmr_dec),
        .zero_o     (tmr_zero)
    );

    always_comb begin
        state_d  = state_q;
        rw_d     = rw_q;
        idecs_d  = idecs_q;
        ior_d    = ior_q;
        iow_d    = iow_q;
        dtack_d  = dtack_q;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        tmr_val  = '0;
        case (state_q)
            ST_IDLE: begin
                if (hit) begin
                    state_d  = ST_SETUP;
                    rw_d     = RW;
                    idecs_d  = A[CS_BIT] ? 2'b01 : 2'b10;
                    tmr_load = 1'b1;
                    tmr_val  = SETUP_LOAD;
                end
            end
            ST_SETUP, ST_ACTIVE, ST_WAITRDY: begin
                if (AS) begin
                    // CPU gave up on the cycle: drop everything, still honour recovery
                    state_d  = ST_RECOVER;
                    idecs_d  = 2'b11;
                    ior_d    = 1'b1;
                    iow_d    = 1'b1;
                    dtack_d  = 1'b1;
                    tmr_load = 1'b1;
                    tmr_val  = RECOVERY_LOAD;
                end else if (state_q == ST_SETUP) begin
                    if (tmr_zero) begin
                        state_d  = ST_ACTIVE;
                        ior_d    = !rw_q;
                        iow_d    = rw_q;
                        tmr_load = 1'b1;
                        tmr_val  = ACTIVE_LOAD;
                    end else begin
                        tmr_dec = 1'b1;
                    end
                end else if ((state_q == ST_ACTIVE) && !tmr_zero) begin
                    tmr_dec = 1'b1;
                end else if (WAIT || ((state_q == ST_WAITRDY) && to_expired)) begin
                    // Write strobe rises with DTACK so data is still held at IOW rising edge
                    state_d = ST_ACK;
                    dtack_d = 1'b0;
                    iow_d   = 1'b1;
                end else begin
                    state_d = ST_WAITRDY;
                end
            end
            ST_ACK: begin
                if (AS) begin
                    state_d  = ST_RECOVER;
                    idecs_d  = 2'b11;
                    ior_d    = 1'b1;
                    iow_d    = 1'b1;
                    dtack_d  = 1'b1;
                    tmr_load = 1'b1;
                    tmr_val  = RECOVERY_LOAD;
                end
            end
            ST_RECOVER: begin
                if (tmr_zero) begin
                    state_d = ST_IDLE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idecs_d = 2'b11;
                ior_d   = 1'b1;
                iow_d   = 1'b1;
                dtack_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            rw_q    <= 1'b1;
            idecs_q <= 2'b11;
            ior_q   <= 1'b1;
            iow_q   <= 1'b1;
            dtack_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rw_q    <= rw_d;
            idecs_q <= idecs_d;
            ior_q   <= ior_d;
            iow_q   <= iow_d;
            dtack_q <= dtack_d;
            busy_q  <= (state_d != ST_IDLE);
        end
    end

`ifdef ATA_IORDY_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] tcnt_q, tcnt_d;
    logic             terr_q, terr_d;

    // Counter idles at zero so it starts clean on every WAITRDY entry
    assign tcnt_d     = (state_q == ST_WAITRDY) ? tcnt_q + 1'b1 : '0;
    assign to_expired = (tcnt_q == TO_LAST);
    assign terr_d     = (state_q == ST_WAITRDY) && !AS && !WAIT && to_expired;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            tcnt_q <= '0;
            terr_q <= 1'b0;
        end else begin
            tcnt_q <= tcnt_d;
            terr_q <= terr_d;
        end
    end

    assign TIMEOUT_ERR = terr_q;
`else
    assign to_expired  = 1'b0;
    assign TIMEOUT_ERR = 1'b0;
`endif

    assign IDECS = idecs_q;
    assign IOR   = ior_q;
    assign IOW   = iow_q;
    assign DTACK = dtack_q;
    assign BUSY  = busy_q;

endmodule

// File: tb/tb_ata_pio_ctl.sv
// tb/tb_ata_pio_ctl.sv - scoreboard bench for ata_pio_ctl
module tb_ata_pio_ctl;

    logic        CLK;
    logic        RESET;
    logic        AS;
    logic        RW;
    logic [23:0] A;
    logic        WAIT;
    logic [1:0]  IDECS;
    logic        IOR;
    logic        IOW;
    logic        DTACK;
    logic        ACCESS;
    logic        BUSY;
    logic        TIMEOUT_ERR;

    ata_pio_ctl dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .AS          (AS),
        .RW          (RW),
        .A           (A),
        .WAIT        (WAIT),
        .IDECS       (IDECS),
        .IOR         (IOR),
        .IOW         (IOW),
        .DTACK       (DTACK),
        .ACCESS      (ACCESS),
        .BUSY        (BUSY),
        .TIMEOUT_ERR (TIMEOUT_ERR)
    );

    typedef struct {
        int         edge_no;
        logic [1:0] idecs;
        logic       ior;
        logic       iow;
        logic       terr;
    } exp_t;

    exp_t sb[$];
    int   edge_n = 0;
    int   checks = 0;
    int   errors = 0;
    int   terr_pulses = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) edge_n <= edge_n + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    task automatic goto(input int n);
        while (edge_n < n) begin
            @(posedge CLK);
            #2;
        end
    endtask

    task automatic push_exp(input int e, input logic [1:0] idecs, input logic ior,
                            input logic iow, input logic terr);
        exp_t x;
        x.edge_no = e;
        x.idecs   = idecs;
        x.ior     = ior;
        x.iow     = iow;
        x.terr    = terr;
        sb.push_back(x);
    endtask

    task automatic monitor();
        logic dt_prev;
        exp_t x;
        dt_prev = 1'b1;
        forever begin
            @(negedge CLK);
            if (TIMEOUT_ERR === 1'b1) terr_pulses++;
            if (dt_prev && (DTACK === 1'b0)) begin
                chk("ack_expected", (sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    x = sb.pop_front();
                    chk("ack_edge", edge_n, x.edge_no);
                    chk("ack_idecs", IDECS, x.idecs);
                    chk("ack_ior", IOR, x.ior);
                    chk("ack_iow", IOW, x.iow);
                    chk("ack_timeout_err", TIMEOUT_ERR, x.terr);
                end
            end
            dt_prev = DTACK;
        end
    endtask

    initial begin
        int t0;
        int cnt_a;
        int cnt_b;
        int terr_base;
        RESET = 1'b1;
        AS    = 1'b1;
        RW    = 1'b1;
        A     = 24'h000000;
        WAIT  = 1'b1;
        fork
            monitor();
        join_none

        goto(2);
        chk("rst_idecs", IDECS, 2'b11);
        chk("rst_ior", IOR, 1'b1);
        chk("rst_iow", IOW, 1'b1);
        chk("rst_dtack", DTACK, 1'b1);
        chk("rst_busy", BUSY, 1'b0);
        chk("rst_terr", TIMEOUT_ERR, 1'b0);
        chk("rst_access_miss", ACCESS, 1'b1);
        RESET = 1'b0;

        // Minimum read, CS1
        goto(5);
        t0 = edge_n;
        A = 24'hDA1000; RW = 1'b1; AS = 1'b0;
        push_exp(t0 + 6, 2'b01, 1'b0, 1'b1, 1'b0);
        #1;
        chk("rd_access_hit", ACCESS, 1'b0);
        chk("rd_idecs_e0", IDECS, 2'b11);
        goto(t0 + 1);
        chk("rd_idecs_e1", IDECS, 2'b01);
        chk("rd_ior_e1", IOR, 1'b1);
        chk("rd_busy_e1", BUSY, 1'b1);
        goto(t0 + 2);
        chk("rd_ior_e2", IOR, 1'b0);
        chk("rd_iow_e2", IOW, 1'b1);
        goto(t0 + 8);
        chk("rd_ior_held", IOR, 1'b0);
        AS = 1'b1;
        goto(t0 + 9);
        chk("rd_rel_ior", IOR, 1'b1);
        chk("rd_rel_dtack", DTACK, 1'b1);
        chk("rd_rel_idecs", IDECS, 2'b11);
        chk("rd_busy_e9", BUSY, 1'b1);
        goto(t0 + 10);
        chk("rd_busy_e10", BUSY, 1'b1);
        goto(t0 + 11);
        chk("rd_busy_e11", BUSY, 1'b0);

        // Write, CS0
        goto(t0 + 13);
        t0 = edge_n;
        A = 24'hDA0000; RW = 1'b0; AS = 1'b0;
        push_exp(t0 + 6, 2'b10, 1'b1, 1'b1, 1'b0);
        cnt_a = 0;
        cnt_b = 0;
        for (int k = 1; k <= 8; k++) begin
            goto(t0 + k);
            if (IOW === 1'b0) cnt_a++;
            if (IOR === 1'b0) cnt_b++;
            if (k == 1) chk("wr_idecs", IDECS, 2'b10);
        end
        chk("wr_iow_width", cnt_a, 4);
        chk("wr_ior_quiet", cnt_b, 0);
        AS = 1'b1;
        RW = 1'b1;

        // Read stretched by IORDY
        goto(t0 + 13);
        t0 = edge_n;
        terr_base = terr_pulses;
        WAIT = 1'b0;
        A = 24'hDA1000; AS = 1'b0;
        push_exp(t0 + 17, 2'b01, 1'b0, 1'b1, 1'b0);
        goto(t0 + 16);
        chk("wt_ior_ext", IOR, 1'b0);
        chk("wt_dtack_wait", DTACK, 1'b1);
        WAIT = 1'b1;
        goto(t0 + 19);
        AS = 1'b1;
        chk("wt_no_terr", terr_pulses - terr_base, 0);

        // IORDY stuck low
        goto(t0 + 24);
        t0 = edge_n;
        terr_base = terr_pulses;
        WAIT = 1'b0;
        A = 24'hDA1000; AS = 1'b0;
`ifdef ATA_IORDY_TIMEOUT_EN
        push_exp(t0 + 206, 2'b01, 1'b0, 1'b1, 1'b1);
        goto(t0 + 205);
        chk("to_terr_before", TIMEOUT_ERR, 1'b0);
        chk("to_dtack_before", DTACK, 1'b1);
        goto(t0 + 207);
        chk("to_terr_after", TIMEOUT_ERR, 1'b0);
        chk("to_dtack_held", DTACK, 1'b0);
        chk("to_pulse_count", terr_pulses - terr_base, 1);
        AS = 1'b1;
        WAIT = 1'b1;
        t0 = t0 + 210;
`else
        push_exp(t0 + 251, 2'b01, 1'b0, 1'b1, 1'b0);
        goto(t0 + 250);
        chk("nt_dtack_wait", DTACK, 1'b1);
        chk("nt_busy", BUSY, 1'b1);
        chk("nt_ior", IOR, 1'b0);
        WAIT = 1'b1;
        goto(t0 + 253);
        AS = 1'b1;
        chk("nt_no_terr", terr_pulses - terr_base, 0);
        t0 = t0 + 256;
`endif

        // Abort during ACTIVE, then back-to-back hit held off by recovery
        goto(t0 + 2);
        t0 = edge_n;
        A = 24'hDA0000; RW = 1'b1; AS = 1'b0;
        goto(t0 + 3);
        chk("ab_ior_active", IOR, 1'b0);
        AS = 1'b1;
        goto(t0 + 4);
        chk("ab_ior_rel", IOR, 1'b1);
        chk("ab_idecs_rel", IDECS, 2'b11);
        chk("ab_dtack", DTACK, 1'b1);
        chk("ab_busy_rec", BUSY, 1'b1);
        AS = 1'b0;
        push_exp(t0 + 12, 2'b10, 1'b0, 1'b1, 1'b0);
        goto(t0 + 6);
        chk("ab_idecs_hold", IDECS, 2'b11);
        chk("ab_busy_idle", BUSY, 1'b0);
        goto(t0 + 7);
        chk("ab_idecs_next", IDECS, 2'b10);
        goto(t0 + 14);
        AS = 1'b1;

        // Miss address
        goto(t0 + 19);
        t0 = edge_n;
        A = 24'hBF0000; AS = 1'b0;
        cnt_a = 0;
        for (int k = 1; k <= 8; k++) begin
            goto(t0 + k);
            if ((IDECS !== 2'b11) || (IOR !== 1'b1) || (IOW !== 1'b1) ||
                (DTACK !== 1'b1) || (BUSY !== 1'b0)) cnt_a++;
        end
        chk("miss_activity", cnt_a, 0);
        chk("miss_access", ACCESS, 1'b1);
        AS = 1'b1;

        // Reset while waiting on IORDY
        goto(t0 + 10);
        t0 = edge_n;
        WAIT = 1'b0;
        A = 24'hDA1000; RW = 1'b1; AS = 1'b0;
        goto(t0 + 9);
        chk("mr_ior_wait", IOR, 1'b0);
        chk("mr_busy_wait", BUSY, 1'b1);
        RESET = 1'b1;
        goto(t0 + 10);
        chk("mr_ior", IOR, 1'b1);
        chk("mr_iow", IOW, 1'b1);
        chk("mr_dtack", DTACK, 1'b1);
        chk("mr_idecs", IDECS, 2'b11);
        chk("mr_busy", BUSY, 1'b0);
        chk("mr_terr", TIMEOUT_ERR, 1'b0);
        RESET = 1'b0;
        AS = 1'b1;
        WAIT = 1'b1;

        goto(t0 + 14);
        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
